// File: rtl/branch_pkg.sv
// branch_pkg: shared FSM states, branch funct3 codes and BHT counter encodings for branch_ctrl.
package branch_pkg;
  typedef enum logic [1:0] {RUN, STALL, REDIRECT} state_e;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [1:0] BHT_SNT = 2'd0;
  localparam logic [1:0] BHT_WNT = 2'd1;
  localparam logic [1:0] BHT_WT  = 2'd2;
  localparam logic [1:0] BHT_ST  = 2'd3;
endpackage

// File: rtl/branch_bht.sv
// branch_bht: table of 2-bit saturating counters; reads see the value before a same-cycle update.
module branch_bht
  import branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             pred_taken,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             taken
);
  localparam int N = 2 ** IDX_W;
  logic [1:0] tbl_q [N];
  logic [1:0] tbl_d [N];
  logic [1:0] cur;
  always_comb begin
    tbl_d = tbl_q;
    cur = tbl_q[wr_idx];
    if (we) tbl_d[wr_idx] = taken ? (cur == BHT_ST ? cur : cur + 2'd1) : (cur == BHT_SNT ? cur : cur - 2'd1);
  end
  assign pred_taken = tbl_q[rd_idx][1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= BHT_WNT;
    end else begin
      tbl_q <= tbl_d;
    end
  end
endmodule

// File: rtl/branch_condition.sv
// branch_condition: evaluates a B-type funct3 comparison; undefined funct3 codes never branch.
module branch_condition
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            branch_flag
);
  always_comb begin
    case (funct3)
      F3_BEQ:  branch_flag = rs1 == rs2;
      F3_BNE:  branch_flag = rs1 != rs2;
      F3_BLT:  branch_flag = $signed(rs1) < $signed(rs2);
      F3_BGE:  branch_flag = $signed(rs1) >= $signed(rs2);
      F3_BLTU: branch_flag = rs1 < rs2;
      F3_BGEU: branch_flag = rs1 >= rs2;
      default: branch_flag = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: EX-stage branch/jump resolution with registered redirect/flush, operand-wait stall and stats.
// Define BRANCH_BHT_EN to add the fetch-side bimodal predictor (branch_bht); otherwise if_pred_taken is 0.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int STALL_MAX = 4,
  parameter int BHT_IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_opnd_pend,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic             stall_o,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_o,
  output logic             misalign_o,
  output logic             err_o,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int SC_W = $clog2(STALL_MAX + 1);
  state_e state_q, state_d;
  logic [SC_W-1:0] scnt_q, scnt_d;
  logic err_q, err_d, rv_q, rv_d, fl_q, fl_d, mis_q, mis_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;
  logic ctrl, flag, taken, mispred, misal, resolve;
  logic [XLEN-1:0] target, seq_pc;
  logic unused_if;
  branch_condition #(.XLEN(XLEN)) u_cond (
    .funct3(ex_funct3),
    .rs1(ex_rs1),
    .rs2(ex_rs2),
    .branch_flag(flag)
  );
  always_comb begin
    ctrl = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
    taken = ex_is_jal | ex_is_jalr | (ex_is_branch & flag);
    target = ex_is_jalr ? (ex_rs1 + ex_imm) & ~XLEN'(1) : ex_pc + ex_imm;
    seq_pc = ex_pc + XLEN'(4);
    mispred = (taken != ex_pred_taken) | (taken & (target != ex_pred_target));
    misal = taken & target[1];
    stall_o = state_q == STALL ? ex_opnd_pend : (state_q == RUN) & ctrl & ex_opnd_pend;
    resolve = (state_q != REDIRECT) & ctrl & ~ex_opnd_pend;
  end
  // the REDIRECT slot holds a wrong-path instruction, so it neither stalls nor resolves
  always_comb begin
    state_d = RUN;
    scnt_d = scnt_q;
    err_d = err_q;
    rv_d = 1'b0;
    fl_d = 1'b0;
    mis_d = 1'b0;
    rpc_d = rpc_q;
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (stall_o) begin
      state_d = STALL;
      scnt_d = state_q != STALL ? SC_W'(1) : scnt_q == SC_W'(STALL_MAX) ? scnt_q : scnt_q + SC_W'(1);
      err_d = err_q | (scnt_d >= SC_W'(STALL_MAX));
    end
    if (resolve) begin
      bcnt_d = bcnt_q + CNT_W'(1);
      rpc_d = taken ? target : seq_pc;
      mis_d = misal;
      rv_d = mispred & ~misal;
      fl_d = rv_d;
      mcnt_d = mcnt_q + CNT_W'(rv_d);
      state_d = rv_d ? REDIRECT : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      scnt_q <= '0;
      err_q <= 1'b0;
      rv_q <= 1'b0;
      fl_q <= 1'b0;
      mis_q <= 1'b0;
      rpc_q <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      state_q <= state_d;
      scnt_q <= scnt_d;
      err_q <= err_d;
      rv_q <= rv_d;
      fl_q <= fl_d;
      mis_q <= mis_d;
      rpc_q <= rpc_d;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end
  assign redirect_valid = rv_q;
  assign redirect_pc = rpc_q;
  assign flush_o = fl_q;
  assign misalign_o = mis_q;
  assign err_o = err_q;
  assign branch_cnt = bcnt_q;
  assign mispred_cnt = mcnt_q;
  assign unused_if = ^if_pc ^ (BHT_IDX_W > 0);
`ifdef BRANCH_BHT_EN
  logic bht_we;
  assign bht_we = resolve & ex_is_branch & ~ex_is_jal & ~ex_is_jalr & ~misal;
  branch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk(clk),
    .rst(rst),
    .rd_idx(if_pc[BHT_IDX_W+1:2]),
    .pred_taken(if_pred_taken),
    .we(bht_we),
    .wr_idx(ex_pc[BHT_IDX_W+1:2]),
    .taken(taken)
  );
`else
  assign if_pred_taken = 1'b0;
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed plus randomized checks of branch_ctrl against a cycle-level behavioural model.
module tb_branch_ctrl;
  localparam int SMAX = 4;
  localparam int IW = 6;
`ifdef BRANCH_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_opnd_pend, ex_pred_taken;
  logic [2:0] ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_target, if_pc;
  logic if_pred_taken, stall_o, redirect_valid, flush_o, misalign_o, err_o;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;
  always #5 clk = ~clk;
  branch_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_opnd_pend(ex_opnd_pend), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .stall_o(stall_o), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_o(flush_o), .misalign_o(misalign_o), .err_o(err_o),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );
  int checks = 0;
  int errors = 0;
  bit m_skip, m_err, m_hold, e_rv, e_mis;
  int m_wait;
  logic [31:0] m_bcnt, m_mcnt, e_rpc;
  int bht [2**IW];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic bit cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  task automatic model_reset();
    m_skip = 0; m_err = 0; m_hold = 0; m_wait = 0;
    m_bcnt = 0; m_mcnt = 0; e_rv = 0; e_mis = 0; e_rpc = 0;
    for (int i = 0; i < 2**IW; i++) bht[i] = 1;
  endtask
  task automatic set_ins(input int kind, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input bit pt, input logic [31:0] ptg,
                         input bit pend);
    ex_valid = kind != 0; ex_is_branch = kind == 1; ex_is_jal = kind == 2; ex_is_jalr = kind == 3;
    ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm;
    ex_pred_taken = pt; ex_pred_target = ptg; ex_opnd_pend = pend; if_pc = pc;
  endtask
  task automatic idle();
    set_ins(0, 3'd0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
  endtask
  // one clock: check combinational outputs, advance the model, then check registered outputs
  task automatic cycle();
    bit ctrl, tk, mp, ma, pred;
    logic [31:0] tgt;
    #1;
    ctrl = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
    pred = BHT_ON && bht[if_pc[IW+1:2]] >= 2;
    if (rst) begin
      model_reset();
    end else begin
      chk("stall", stall_o, ctrl & ex_opnd_pend & !m_skip);
      chk("if_pred", if_pred_taken, pred);
      e_rv = 0; e_mis = 0;
      m_hold = ctrl && ex_opnd_pend && !m_skip;
      if (m_skip) begin
        m_skip = 0; m_wait = 0;
      end else if (m_hold) begin
        m_wait++;
        if (m_wait >= SMAX) m_err = 1;
      end else begin
        m_wait = 0;
        if (ctrl) begin
          tk = ex_is_jal || ex_is_jalr || (ex_is_branch && cond(ex_funct3, ex_rs1, ex_rs2));
          tgt = ex_is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : ex_pc + ex_imm;
          mp = (tk != ex_pred_taken) || (tk && tgt != ex_pred_target);
          ma = tk && tgt[1];
          m_bcnt++;
          if (ma) e_mis = 1;
          else if (mp) begin
            e_rv = 1; e_rpc = tk ? tgt : ex_pc + 4; m_mcnt++; m_skip = 1;
          end
          if (ex_is_branch && !ma)
            bht[ex_pc[IW+1:2]] = tk ? (bht[ex_pc[IW+1:2]] == 3 ? 3 : bht[ex_pc[IW+1:2]] + 1)
                                    : (bht[ex_pc[IW+1:2]] == 0 ? 0 : bht[ex_pc[IW+1:2]] - 1);
        end
      end
    end
    @(negedge clk);
    chk("redirect_valid", redirect_valid, e_rv);
    chk("flush", flush_o, e_rv);
    chk("misalign", misalign_o, e_mis);
    chk("err", err_o, m_err);
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("mispred_cnt", mispred_cnt, m_mcnt);
    if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
  endtask
  task automatic do_reset();
    rst = 1; idle(); cycle(); rst = 0;
  endtask
  initial begin
    logic [31:0] pc, imm, tgt;
    int kind;
    rst = 1; idle();
    @(negedge clk);
    cycle(); rst = 0;
    chk("rst_bcnt", branch_cnt, 0);
    chk("rst_redirect", redirect_valid, 0);
    set_ins(1, 3'd0, 5, 5, 32'h100, 32'h20, 1'b0, 0, 1'b0); cycle();
    chk("beq_rpc", redirect_pc, 32'h120);
    chk("beq_flush", flush_o, 1);
    chk("beq_mcnt", mispred_cnt, 1);
    set_ins(1, 3'd0, 1, 1, 32'h200, 32'h8, 1'b0, 0, 1'b0); cycle();
    chk("slot_flush", flush_o, 0);
    chk("slot_bcnt", branch_cnt, 1);
    chk("slot_mcnt", mispred_cnt, 1);
    set_ins(1, 3'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 1'b1, 32'h340, 1'b0); cycle();
    chk("blt_redirect", redirect_valid, 0);
    chk("blt_bcnt", branch_cnt, 2);
    set_ins(3, 3'd0, 32'h203, 0, 32'h500, 0, 1'b0, 0, 1'b0); cycle();
    chk("jalr_mis", misalign_o, 1);
    chk("jalr_mis_rv", redirect_valid, 0);
    chk("jalr_mis_pc", redirect_pc, 32'h202);
    chk("jalr_mis_mcnt", mispred_cnt, 1);
    set_ins(3, 3'd0, 32'hFF8, 0, 32'h500, 32'h8, 1'b0, 0, 1'b0); cycle();
    chk("jalr_rv", redirect_valid, 1);
    chk("jalr_rpc", redirect_pc, 32'h1000);
    idle(); cycle();
    for (int k = 1; k <= 5; k++) begin
      set_ins(1, 3'd1, 1, 2, 32'h400, 32'h10, 1'b1, 32'h410, 1'b1); cycle();
      chk("bne_err", err_o, k >= SMAX);
    end
    set_ins(1, 3'd1, 1, 2, 32'h400, 32'h10, 1'b1, 32'h410, 1'b0); cycle();
    chk("bne_bcnt", branch_cnt, 5);
    chk("bne_rv", redirect_valid, 0);
    idle(); cycle();
    do_reset();
    set_ins(1, 3'd0, 3, 3, 32'h40, 32'h10, 1'b1, 32'h50, 1'b0); cycle();
    chk("bht_after1", if_pred_taken, BHT_ON);
    cycle();
    chk("bht_after2", if_pred_taken, BHT_ON);
    set_ins(1, 3'd1, 1, 2, 32'h400, 32'h10, 1'b1, 32'h410, 1'b1); cycle(); cycle();
    do_reset();
    chk("rst_stall", stall_o, 0);
    chk("rst_stall_bcnt", branch_cnt, 0);
    set_ins(1, 3'd0, 5, 5, 32'h100, 32'h20, 1'b0, 0, 1'b0); cycle();
    do_reset();
    chk("rst_redir_rv", redirect_valid, 0);
    chk("rst_redir_flush", flush_o, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      if (m_hold) begin
        ex_opnd_pend = $urandom_range(0, 4) != 0;
      end else begin
        kind = $urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(1, 3));
        pc = 32'($urandom_range(0, 255)) << 2;
        imm = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) << 2 : 32'($urandom_range(0, 31)) << 1;
        if ($urandom_range(0, 1)) imm = -imm;
        set_ins(kind, 3'($urandom_range(0, 7)),
                $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
                $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
                pc, imm, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 3) == 0);
        tgt = kind == 3 ? ((ex_rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
        ex_pred_target = $urandom_range(0, 3) != 0 ? tgt : pc + 4;
        if ($urandom_range(0, 7) == 0) ex_valid = ~ex_valid;
        if ($urandom_range(0, 1)) if_pc = 32'($urandom_range(0, 255)) << 2;
      end
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
